// File: rtl/udt_pkg.sv
// UDT handshake shared definitions.
// Control word, connection types, beat map and parsed handshake fields.
package udt_pkg;

  localparam logic [31:0] UDT_CTRL_HS  = 32'h8000_0000;
  localparam logic [31:0] CONN_REQ     = 32'h0000_0001;
  localparam logic [31:0] CONN_ACCEPT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CONN_REJECT  = 32'hFFFF_FFFE;
  localparam logic [31:0] SOCK_STREAM  = 32'd1;
  localparam logic [31:0] HDR_IP_UDP   = 32'd28;
  localparam logic [31:0] HDR_UDT      = 32'd16;
  localparam logic [31:0] MIN_PEER_MSS = 32'd44;

  typedef enum logic [2:0] {
    B_HDR, B_TS, B_VER, B_ISN,
    B_FLT, B_SID, B_IPH, B_IPL
  } hs_beat_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_REQ,
    S_WAIT_COOKIE,
    S_SEND_CONF,
    S_WAIT_RSP,
    S_CONNECTED
  } conn_state_e;

  typedef struct packed {
    logic [31:0]  version;
    logic [31:0]  sock_type;
    logic [31:0]  isn;
    logic [31:0]  mss;
    logic [31:0]  flight;
    logic [31:0]  conn_type;
    logic [31:0]  sock_id;
    logic [31:0]  cookie;
    logic [127:0] peer_ip;
  } hs_info_t;

  function automatic logic [31:0] min32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/udt_connect_rx_parser.sv
// Handshake RX frame parser: counts beats, checks framing, captures fields.
// Emits a registered one-cycle frame_ok or frame_bad after each tlast.
module udt_hs_rx_parser
  import udt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] rx_tdata,
  input  logic [7:0]  rx_tkeep,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  input  logic        rx_tready,
  input  logic [31:0] local_sock_id,
  output hs_info_t    info,
  output logic        frame_ok,
  output logic        frame_bad
);

  logic [3:0] cnt_q, cnt_d;
  logic       bad_q, bad_d;
  logic       ok_q, ok_d;
  logic       badp_q, badp_d;
  hs_info_t   info_q, info_d;
  logic       fire;
  logic       beat_err;
  logic [31:0] wa, wb;

  // Per-beat checks, field capture and resync on tlast
  always_comb begin
    fire     = rx_tvalid & rx_tready;
    wa       = rx_tdata[63:32];
    wb       = rx_tdata[31:0];
    beat_err = (rx_tkeep != 8'hFF);
    if (cnt_q == 4'd0 && wa != UDT_CTRL_HS)
      beat_err = 1'b1;
    if (cnt_q == 4'd1 && wb != local_sock_id && wb != 32'd0)
      beat_err = 1'b1;
    if (cnt_q >= 4'd7 && !rx_tlast)
      beat_err = 1'b1;
    if (rx_tlast && cnt_q != 4'd7)
      beat_err = 1'b1;
    cnt_d  = cnt_q;
    bad_d  = bad_q;
    info_d = info_q;
    ok_d   = 1'b0;
    badp_d = 1'b0;
    if (fire) begin
      case (cnt_q)
        4'd2: begin
          info_d.version   = wa;
          info_d.sock_type = wb;
        end
        4'd3: begin
          info_d.isn = wa;
          info_d.mss = wb;
        end
        4'd4: begin
          info_d.flight    = wa;
          info_d.conn_type = wb;
        end
        4'd5: begin
          info_d.sock_id = wa;
          info_d.cookie  = wb;
        end
        4'd6: info_d.peer_ip[127:64] = rx_tdata;
        4'd7: info_d.peer_ip[63:0]   = rx_tdata;
        default: ;
      endcase
      if (rx_tlast) begin
        cnt_d  = 4'd0;
        bad_d  = 1'b0;
        ok_d   = !(bad_q | beat_err);
        badp_d = bad_q | beat_err;
      end else begin
        bad_d = bad_q | beat_err;
        if (cnt_q != 4'd8)
          cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Parser state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bad_q  <= 1'b0;
      ok_q   <= 1'b0;
      badp_q <= 1'b0;
      info_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bad_q  <= bad_d;
      ok_q   <= ok_d;
      badp_q <= badp_d;
      info_q <= info_d;
    end
  end

  assign info      = info_q;
  assign frame_ok  = ok_q;
  assign frame_bad = badp_q;

endmodule

// File: rtl/udt_connect.sv
// UDT caller-side handshake: request, cookie echo, accept latch.
// Owns the TX frame serialiser, retransmit timer and retry counter.
module udt_connect
  import udt_pkg::*;
#(
  parameter int unsigned RETX_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRY   = 8,
  parameter int unsigned UDT_VERSION = 4
) (
  input  logic         clk,
  input  logic         core_rst_n,
  input  logic         Req_Connect,
  input  logic         Req_Close,
  input  logic [31:0]  MSSize,
  input  logic [31:0]  FlightFlagSize,
  input  logic [31:0]  LocalISN,
  input  logic [31:0]  LocalSocketID,
  input  logic [31:0]  Timestamp,
  input  logic [127:0] PeerIP,
  output logic [63:0]  hs_tx_tdata,
  output logic [7:0]   hs_tx_tkeep,
  output logic         hs_tx_tvalid,
  output logic         hs_tx_tlast,
  input  logic         hs_tx_tready,
  input  logic [63:0]  hs_rx_tdata,
  input  logic [7:0]   hs_rx_tkeep,
  input  logic         hs_rx_tvalid,
  input  logic         hs_rx_tlast,
  output logic         hs_rx_tready,
  output logic         Res_Connect,
  output logic         Res_Close,
  output logic         err,
  output logic [31:0]  PeerISN,
  output logic [31:0]  PeerSocketID,
  output logic [31:0]  Max_PktSize,
  output logic [31:0]  Max_PayloadSize,
  output logic [31:0]  FlowWindowSize
);

  localparam logic [31:0] RETX_LAST = 32'(RETX_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
  localparam logic [31:0] VER_WORD  = 32'(UDT_VERSION);

  conn_state_e  state_q, state_d;
  hs_beat_e     beat_q, beat_d;
  logic [7:0]   retry_q, retry_d;
  logic [31:0]  timer_q, timer_d;
  logic [31:0]  cookie_q, cookie_d;
  logic [31:0]  ts_q, isn_q, mss_q, flt_q, sid_q;
  logic [127:0] pip_q;
  logic         pend_q, pend_d;
  logic         rdy_q;
  logic         conn_q, conn_d;
  logic         clsp_q, clsp_d;
  logic         err_q, err_d;
  logic [31:0]  pisn_q, pisn_d;
  logic [31:0]  psid_q, psid_d;
  logic [31:0]  pkt_q, pkt_d;
  logic [31:0]  pay_q, pay_d;
  logic [31:0]  win_q, win_d;

  hs_info_t     rx_info;
  logic         frame_ok;
  logic         frame_bad;
  logic         unused_info;
  logic         tx_send;
  logic         tx_fire;
  logic         tx_done;
  logic         timeout;
  logic         load;
  logic [31:0]  word_a, word_b;

  udt_hs_rx_parser u_rx (
    .clk           (clk),
    .rst_n         (core_rst_n),
    .rx_tdata      (hs_rx_tdata),
    .rx_tkeep      (hs_rx_tkeep),
    .rx_tvalid     (hs_rx_tvalid),
    .rx_tlast      (hs_rx_tlast),
    .rx_tready     (rdy_q),
    .local_sock_id (LocalSocketID),
    .info          (rx_info),
    .frame_ok      (frame_ok),
    .frame_bad     (frame_bad)
  );

  assign unused_info = ^{rx_info.version, rx_info.sock_type,
                         rx_info.peer_ip, frame_bad};

  assign tx_send = (state_q == S_SEND_REQ) || (state_q == S_SEND_CONF);
  assign tx_fire = tx_send & hs_tx_tready;
  assign tx_done = tx_fire && (beat_q == B_IPL);
  assign timeout = (timer_q >= RETX_LAST);

  // State and frame snapshot registers
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= B_HDR;
      retry_q  <= '0;
      timer_q  <= '0;
      cookie_q <= '0;
      ts_q     <= '0;
      isn_q    <= '0;
      mss_q    <= '0;
      flt_q    <= '0;
      sid_q    <= '0;
      pip_q    <= '0;
      pend_q   <= 1'b0;
      rdy_q    <= 1'b0;
      conn_q   <= 1'b0;
      clsp_q   <= 1'b0;
      err_q    <= 1'b0;
      pisn_q   <= '0;
      psid_q   <= '0;
      pkt_q    <= '0;
      pay_q    <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      cookie_q <= cookie_d;
      if (load) begin
        ts_q  <= Timestamp;
        isn_q <= LocalISN;
        mss_q <= MSSize;
        flt_q <= FlightFlagSize;
        sid_q <= LocalSocketID;
        pip_q <= PeerIP;
      end
      pend_q   <= pend_d;
      rdy_q    <= 1'b1;
      conn_q   <= conn_d;
      clsp_q   <= clsp_d;
      err_q    <= err_d;
      pisn_q   <= pisn_d;
      psid_q   <= psid_d;
      pkt_q    <= pkt_d;
      pay_q    <= pay_d;
      win_q    <= win_d;
    end
  end

  // Next-state: handshake sequencing, retransmit and close handling
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    cookie_d = cookie_q;
    pend_d   = pend_q;
    conn_d   = 1'b0;
    clsp_d   = 1'b0;
    err_d    = 1'b0;
    pisn_d   = pisn_q;
    psid_d   = psid_q;
    pkt_d    = pkt_q;
    pay_d    = pay_q;
    win_d    = win_q;
    load     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Req_Close) begin
          clsp_d = 1'b1;
        end else if (Req_Connect) begin
          state_d  = S_SEND_REQ;
          beat_d   = B_HDR;
          cookie_d = '0;
          retry_d  = '0;
          load     = 1'b1;
        end
      end
      S_SEND_REQ, S_SEND_CONF: begin
        if (Req_Close)
          pend_d = 1'b1;
        if (tx_fire)
          beat_d = hs_beat_e'(beat_q + 3'd1);
        if (tx_done) begin
          beat_d  = B_HDR;
          timer_d = '0;
          if (pend_q || Req_Close) begin
            state_d = S_IDLE;
            clsp_d  = 1'b1;
            pend_d  = 1'b0;
          end else if (state_q == S_SEND_REQ) begin
            state_d = S_WAIT_COOKIE;
          end else begin
            state_d = S_WAIT_RSP;
          end
        end
      end
      S_WAIT_COOKIE: begin
        timer_d = timer_q + 32'd1;
        if (Req_Close) begin
          state_d = S_IDLE;
          clsp_d  = 1'b1;
        end else if (frame_ok) begin
          if (rx_info.conn_type == CONN_REQ &&
              rx_info.cookie != 32'd0) begin
            cookie_d = rx_info.cookie;
            retry_d  = '0;
            state_d  = S_SEND_CONF;
            load     = 1'b1;
          end
        end else if (timeout) begin
          if (retry_q == RETRY_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = S_SEND_REQ;
            load    = 1'b1;
          end
        end
      end
      S_WAIT_RSP: begin
        timer_d = timer_q + 32'd1;
        if (Req_Close) begin
          state_d = S_IDLE;
          clsp_d  = 1'b1;
        end else if (frame_ok) begin
          if (rx_info.conn_type == CONN_ACCEPT) begin
            if (rx_info.mss < MIN_PEER_MSS) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_CONNECTED;
              conn_d  = 1'b1;
              pisn_d  = rx_info.isn;
              psid_d  = rx_info.sock_id;
              pkt_d   = min32(mss_q, rx_info.mss) - HDR_IP_UDP;
              pay_d   = pkt_d - HDR_UDT;
              win_d   = min32(flt_q, rx_info.flight);
            end
          end else if (rx_info.conn_type == CONN_REJECT) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          if (retry_q == RETRY_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = S_SEND_CONF;
            load    = 1'b1;
          end
        end
      end
      S_CONNECTED: begin
        if (Req_Close) begin
          state_d = S_IDLE;
          clsp_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: serialise the current beat, gated to zero when idle
  always_comb begin
    word_a = '0;
    word_b = '0;
    case (beat_q)
      B_HDR: word_a = UDT_CTRL_HS;
      B_TS:  word_a = ts_q;
      B_VER: begin
        word_a = VER_WORD;
        word_b = SOCK_STREAM;
      end
      B_ISN: begin
        word_a = isn_q;
        word_b = mss_q;
      end
      B_FLT: begin
        word_a = flt_q;
        word_b = CONN_REQ;
      end
      B_SID: begin
        word_a = sid_q;
        word_b = cookie_q;
      end
      B_IPH: {word_a, word_b} = pip_q[127:64];
      B_IPL: {word_a, word_b} = pip_q[63:0];
      default: ;
    endcase
    hs_tx_tvalid = tx_send;
    hs_tx_tdata  = tx_send ? {word_a, word_b} : 64'd0;
    hs_tx_tkeep  = tx_send ? 8'hFF : 8'h00;
    hs_tx_tlast  = tx_send && (beat_q == B_IPL);
  end

  assign hs_rx_tready    = rdy_q;
  assign Res_Connect     = conn_q;
  assign Res_Close       = clsp_q;
  assign err             = err_q;
  assign PeerISN         = pisn_q;
  assign PeerSocketID    = psid_q;
  assign Max_PktSize     = pkt_q;
  assign Max_PayloadSize = pay_q;
  assign FlowWindowSize  = win_q;

endmodule

// File: doc/udt_connect.md
Name: udt_connect

Overview:
- Caller (client) side of the UDT connection handshake; the peer end of the listen block.
- On Req_Connect it serialises a UDT handshake request onto a 64-bit AXI-Stream, waits for the listener's cookie reply, and re-sends the request carrying that cookie.
- On the final accept it latches the peer and negotiated session values and pulses Res_Connect.
- Sits between the connection-control logic and the UDP TX/RX handshake stream muxes.

Parameters:
- RETX_CYCLES, 1_000_000: clk cycles a WAIT state lasts before the current request is retransmitted.
- MAX_RETRY, 8: retransmissions allowed before the block gives up.
- UDT_VERSION, 4: value sent in the version field.

Ports:
- clk in 1: clock.
- core_rst_n in 1: asynchronous active-low reset.
- Req_Connect in 1: start handshake (level; sampled in IDLE).
- Req_Close in 1: abort or close.
- MSSize in 32: local MSS.
- FlightFlagSize in 32: local flow window.
- LocalISN in 32: initial sequence number.
- LocalSocketID in 32: local socket id.
- Timestamp in 32: microsecond counter.
- PeerIP in 128: peer address field.
- hs_tx_tdata out 64, hs_tx_tkeep out 8, hs_tx_tvalid out 1, hs_tx_tlast out 1: handshake TX stream.
- hs_tx_tready in 1: TX stream ready.
- hs_rx_tdata in 64, hs_rx_tkeep in 8, hs_rx_tvalid in 1, hs_rx_tlast in 1: handshake RX stream.
- hs_rx_tready out 1: RX stream ready.
- Res_Connect out 1: one-cycle pulse on accept.
- Res_Close out 1: one-cycle pulse on close completion.
- err out 1: one-cycle pulse when retries are exhausted or the handshake is rejected.
- PeerISN out 32: latched from the accept packet.
- PeerSocketID out 32: latched from the accept packet.
- Max_PktSize out 32: negotiated packet size.
- Max_PayloadSize out 32: negotiated payload size.
- FlowWindowSize out 32: negotiated flow window.

Behaviour:
- Reset: all outputs 0, state IDLE, retry count 0, timer 0, latched cookie 0.
- Frame format: 8 beats, tkeep=8'hFF on every beat, tlast on beat 7 only. Word A = [63:32], word B = [31:0], big-endian.
  - b0: A=32'h8000_0000 (control, type 0), B=0.
  - b1: A=Timestamp (sampled at beat 0), B=0.
  - b2: A=UDT_VERSION, B=1 (STREAM).
  - b3: A=LocalISN, B=MSSize.
  - b4: A=FlightFlagSize, B=conn_type=1.
  - b5: A=LocalSocketID, B=cookie.
  - b6: PeerIP[127:64].
  - b7: PeerIP[63:0].
- TX handshake:
  - A beat advances only when tvalid && tready.
  - tdata and tvalid are held stable while tready=0.
  - Inputs are captured at entry to a SEND state and are constant for the whole frame.
- States:
  - IDLE: Req_Connect=1 -> SEND_REQ with cookie=0 and retry=0.
  - SEND_REQ: after beat 7 accepted -> WAIT_COOKIE, timer=0.
  - WAIT_COOKIE: on a valid RX frame with conn_type=1 and cookie!=0, latch cookie -> SEND_CONF with retry=0.
  - SEND_CONF: same frame with the latched cookie. After beat 7 -> WAIT_RSP.
  - WAIT_RSP:
    - conn_type=32'hFFFF_FFFF -> CONNECTED; latch peer fields; Res_Connect pulses in the cycle CONNECTED is entered.
    - conn_type=32'hFFFF_FFFE (reject) -> err pulse -> IDLE.
  - CONNECTED: stays until Req_Close.
- Timeout:
  - In either WAIT state, the timer reaching RETX_CYCLES-1 resends the previous frame and increments retry.
  - With retry==MAX_RETRY, an expiry pulses err and goes to IDLE instead of resending.
- RX path:
  - hs_rx_tready=1 in all states; frames are consumed and discarded outside the WAIT states.
  - A frame is valid only if: exactly 8 beats, tlast on beat 7, all tkeep=8'hFF, b0 A=32'h8000_0000, and b1 B (dest id) equals LocalSocketID or 0.
  - An early tlast, or a beat 8 without tlast, discards the frame; the parser resyncs at the next beat after tlast.
  - A valid frame that arrives in the same cycle as a timeout takes priority; the timeout is ignored.
- Negotiation:
  - Max_PktSize = min(MSSize, peer MSS) - 28.
  - Max_PayloadSize = Max_PktSize - 16.
  - FlowWindowSize = min(FlightFlagSize, peer flight).
  - All unsigned 32-bit. Peer MSS < 44 is treated as a reject.
- Req_Close:
  - In WAIT or CONNECTED: -> IDLE next cycle with a Res_Close pulse.
  - In a SEND state: the current frame finishes, then -> IDLE with Res_Close.
  - In IDLE: Res_Close pulses and the state is unchanged.
  - Latched outputs are held until the next connect.
- Reset mid-frame: tvalid drops immediately (asynchronous), per reset.

Decomposition:
- Shared package udt_pkg:
  - UDT_CTRL_HS word.
  - Conn-type constants CONN_REQ=1, CONN_ACCEPT=-1, CONN_REJECT=-2.
  - Handshake beat-index enum.
  - Typedef hs_info_t: version, sock_type, isn, mss, flight, conn_type, sock_id, cookie, peer_ip.
  - Header overhead constants 28/16.
- Sub-module udt_hs_rx_parser: beat counter plus field capture. It outputs an hs_info_t and a one-cycle frame_ok / frame_bad pulse. The top FSM owns TX and the timer.

Test Plan:
- Req_Connect=1, ISN=32'h1234, MSS=1500; cookie reply 32'hCAFE; then accept with MSS 1400, flight 8192 vs local 25600. Required:
  - Two TX frames; second frame b5 B=32'hCAFE.
  - Res_Connect 1 cycle; Max_PktSize=1372, Max_PayloadSize=1356, FlowWindowSize=8192.
- hs_tx_tready toggling 1-0-1 every cycle during SEND_REQ -> tdata stable while stalled; exactly 8 handshakes; tlast only on beat 8.
- No reply, RETX_CYCLES=16, MAX_RETRY=2 -> 3 identical request frames, then err pulse and IDLE after the third timeout.
- Reply with tlast on beat 5, then a correct reply -> first ignored, second accepted, no err.
- Reject (conn_type 32'hFFFF_FFFE) in WAIT_RSP -> err pulse, IDLE, Res_Connect never asserts.
- Req_Close during beat 3 of SEND_CONF -> frame completes to beat 7, Res_Close pulses once, IDLE; core_rst_n low mid-frame -> all outputs 0 immediately.
